// File: rtl/seq_subtractor_64bit_if.sv
// Request/result bundle for the slice-serial 64-bit subtractor.
// master = requester (drives operands and start), slave = subtractor.
interface seq_subtractor_64bit_if;
    logic        start;
    logic [63:0] in1;
    logic [63:0] in2;
    logic        b_in;
    logic        busy;
    logic        done;
    logic [63:0] diff;
    logic        b_out;
    logic        zero;
    logic        overflow;

    modport master (
        output start, in1, in2, b_in,
        input  busy, done, diff, b_out, zero, overflow
    );

    modport slave (
        input  start, in1, in2, b_in,
        output busy, done, diff, b_out, zero, overflow
    );
endinterface

// File: rtl/seq_subtractor_64bit.sv
// Multi-cycle 64-bit subtractor: diff = in1 - in2 - b_in, one SLICE_W-bit
// slice per clock with the borrow carried between slices in a register.
module seq_subtractor_64bit #(
    parameter int SLICE_W = 8
) (
    input logic                   clk,
    input logic                   rst,
    seq_subtractor_64bit_if.slave bus
);
    localparam int DATA_W = 64;
    localparam int N      = DATA_W / SLICE_W;
    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Borrow-out lands in the extra MSB: a negative result wraps it to 1.
    function automatic logic [SLICE_W:0] slice_sub(
        input logic [SLICE_W-1:0] x,
        input logic [SLICE_W-1:0] y,
        input logic               bin
    );
        return {1'b0, x} - {1'b0, y} - {{SLICE_W{1'b0}}, bin};
    endfunction

    function automatic logic signed_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic d_msb
    );
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

    state_t             state_q;
    state_t             state_d;
    logic               load;
    logic               step;
    logic               last;

    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  w_q;
    logic [DATA_W-1:0]  w_d;
    logic               borrow_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W:0]   sub_res;

    logic [DATA_W-1:0]  diff_q;
    logic               b_out_q;
    logic               zero_q;
    logic               ovf_q;

    assign last = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Slice datapath: select slice cnt_q, subtract, merge into working word.
    always_comb begin
        a_sl    = a_q[int'(cnt_q) * SLICE_W +: SLICE_W];
        b_sl    = b_q[int'(cnt_q) * SLICE_W +: SLICE_W];
        sub_res = slice_sub(a_sl, b_sl, borrow_q);
        w_d     = w_q;
        w_d[int'(cnt_q) * SLICE_W +: SLICE_W] = sub_res[SLICE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            w_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            b_out_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (load) begin
            a_q      <= bus.in1;
            b_q      <= bus.in2;
            borrow_q <= bus.b_in;
            cnt_q    <= '0;
            w_q      <= '0;
        end else if (step) begin
            w_q      <= w_d;
            borrow_q <= sub_res[SLICE_W];
            cnt_q    <= last ? '0 : cnt_q + 1'b1;
            // Result flags are published only here so they never move mid-run.
            if (last) begin
                diff_q  <= w_d;
                b_out_q <= sub_res[SLICE_W];
                zero_q  <= (w_d == '0);
                ovf_q   <= signed_ovf(a_q[DATA_W-1], b_q[DATA_W-1], w_d[DATA_W-1]);
            end
        end
    end

    assign bus.busy     = (state_q == ST_RUN);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.diff     = diff_q;
    assign bus.b_out    = b_out_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ovf_q;
endmodule

// File: doc/seq_subtractor_64bit.md
# seq_subtractor_64bit

Multi-cycle 64-bit unsigned/two's-complement subtractor computing `diff = in1 - in2 - b_in`, processed one `SLICE_W`-bit slice per clock with a ripple borrow register between slices. It is the inverse-direction companion of the 64-bit ripple-carry adder in the arithmetic library. It trades the adder's single long combinational chain for a short per-cycle path. Intended for datapaths that issue an operation with `start` and wait for `done`.

## Interface
- `SLICE_W`, default 8: bits processed per cycle; legal values 1, 2, 4, 8, 16, 32, 64.
- `N` (localparam) = 64 / `SLICE_W`: number of RUN cycles.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `in1`  in  64  minuend; captured on the accepted `start` edge.
- `in2`  in  64  subtrahend; captured on the accepted `start` edge.
- `b_in`  in  1  borrow-in; captured on the accepted `start` edge.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; result valid.
- `diff`  out  64  result; held until the next completion.
- `b_out`  out  1  final borrow; 1 iff in1 < in2 + b_in as unsigned values.
- `zero`  out  1  diff == 0.
- `overflow`  out  1  signed overflow: (in1[63] != in2[63]) && (diff[63] != in1[63]).

## Operation
- One clock domain; reset is synchronous and active-high.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on `start`.
  - RUN -> DONE when slice N-1 is processed.
  - DONE -> RUN on `start`; otherwise DONE -> IDLE.
- On an accepted start, capture `in1`, `in2` and `b_in`:
  - Operand registers A, B <= in1, in2.
  - Borrow register <= b_in.
  - Slice counter <= 0.
  - Working register W <= 0.
- Each RUN cycle, slice index i = counter:
  - {borrow', s} = A[i] - B[i] - borrow, computed at `SLICE_W`+1 bits.
  - W[i] <= s; borrow <= borrow'; counter <= counter + 1.
  - Borrow-out of a slice is 1 iff A[i] < B[i] + borrow.
- On the last slice, W is forwarded to the outputs:
  - `diff` <= final W, including the last slice.
  - `b_out` <= final borrow.
  - `zero` and `overflow` are computed from the captured A, B and the final diff.
- `diff`, `b_out`, `zero` and `overflow` change only on a completion edge, never during RUN.
- `start` while in RUN is ignored; operands are not re-captured.
- Input changes after capture have no effect on the operation in flight.
- Counter is `$clog2(N)`-bit wide, minimum 1 bit. It wraps to 0 at completion; no other wrap occurs.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `diff`=0, `b_out`=0, `zero`=0, `overflow`=0; internal registers 0.
- `rst` asserted mid-RUN aborts the operation at that edge. Outputs return to reset values; no `done` is produced.
- `rst` has priority over `start` on the same edge.
- Accepted `start` at edge E0:
  - `busy`=1 after E0.
  - Slice i is processed at edge E(i+1).
  - At edge EN, outputs are updated, `busy`=0, `done`=1.
- Latency is N cycles from the start edge to `done` high (8 cycles at the default).
- `done` is high for exactly one cycle.
- Back-to-back: `start` held high in the DONE cycle is accepted at the next edge. `busy` then returns to 1 while `done` falls to 0. Throughput is one result per N+1 cycles.
- `start` held continuously produces one result every N+1 cycles.
- Critical path is one `SLICE_W`+1-bit subtract plus the borrow flop.

## Test plan
- Reset, then in1=98345672198765, in2=12765438912345, b_in=0, start -> `done` 8 cycles later; diff=85580233286420, b_out=0, zero=0, overflow=0.
- Operands swapped -> diff=18446658493476265196, b_out=1, overflow=0.
- in1=0, in2=1 -> diff=64'hFFFF_FFFF_FFFF_FFFF, b_out=1, overflow=0. This exercises the full borrow chain across every slice.
- in1=64'h8000_0000_0000_0000, in2=1 -> diff=64'h7FFF_FFFF_FFFF_FFFF, overflow=1, b_out=0.
- in1=5, in2=5, b_in=0 -> diff=0, zero=1. Then in1=10, in2=3, b_in=1 -> diff=6, zero=0.
- Two checks in one run:
  - Pulse `start` with new operands at RUN cycle 3 -> ignored; the first result is unchanged.
  - Assert `rst` at RUN cycle 5 -> no `done`; all outputs 0 on the next cycle.
- Repeat the scenarios with SLICE_W=1 (latency 64) and SLICE_W=64 (latency 1).
